// File: rtl/psram_arb_if.sv
// rtl/psram_arb_if.sv - requester ports and PSRAM bus of the PSRAM arbiter
// Signals:
//   a_req/a_addr/a_din/a_we_lo/a_we_hi -> a_dout/a_ack : port A (MD mapper, priority)
//   b_req/b_addr/b_din/b_we_lo/b_we_hi -> b_dout/b_ack : port B (MCU/SPI DMA, bounded wait)
//   ram0_dato -> ram0_dati/ram0_addr/ram0_ce/ram0_oe/ram0_we_lo/ram0_we_hi : PSRAM pins
// Modports: slave = arbiter view, master = requesters plus PSRAM view.
interface psram_arb_if;
  logic        a_req;
  logic [22:0] a_addr;
  logic [15:0] a_din;
  logic        a_we_lo;
  logic        a_we_hi;
  logic [15:0] a_dout;
  logic        a_ack;

  logic        b_req;
  logic [22:0] b_addr;
  logic [15:0] b_din;
  logic        b_we_lo;
  logic        b_we_hi;
  logic [15:0] b_dout;
  logic        b_ack;

  logic [15:0] ram0_dato;
  logic [15:0] ram0_dati;
  logic [22:0] ram0_addr;
  logic        ram0_ce;
  logic        ram0_oe;
  logic        ram0_we_lo;
  logic        ram0_we_hi;

  modport slave (
    input  a_req, a_addr, a_din, a_we_lo, a_we_hi,
    output a_dout, a_ack,
    input  b_req, b_addr, b_din, b_we_lo, b_we_hi,
    output b_dout, b_ack,
    input  ram0_dato,
    output ram0_dati, ram0_addr, ram0_ce, ram0_oe, ram0_we_lo, ram0_we_hi
  );

  modport master (
    output a_req, a_addr, a_din, a_we_lo, a_we_hi,
    input  a_dout, a_ack,
    output b_req, b_addr, b_din, b_we_lo, b_we_hi,
    input  b_dout, b_ack,
    output ram0_dato,
    input  ram0_dati, ram0_addr, ram0_ce, ram0_oe, ram0_we_lo, ram0_we_hi
  );
endinterface

// File: rtl/psram_arb.sv
// rtl/psram_arb.sv - two-port PSRAM arbiter and fixed-length access sequencer
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : psram_arb_if.slave - requester ports A/B and the ram0_* PSRAM bus
// Parameters:
//   ACC_CYC    : cycles CE is held low per access (3..15)
//   B_MAX_SKIP : A grants tolerated while B waits before B is forced (1..15)
module psram_arb #(
  parameter int unsigned ACC_CYC    = 4,
  parameter int unsigned B_MAX_SKIP = 2
) (
  input  logic       clk,
  input  logic       rst,
  psram_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC, GAP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACC_CYC - 1);
  localparam logic [3:0] SKIP_MAX = 4'(B_MAX_SKIP);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  skip_q, skip_d;
  logic        sel_b_q, sel_b_d;
  logic [1:0]  mask_q, mask_d;
  logic        ce_q, ce_d;
  logic        oe_q, oe_d;
  logic        we_lo_q, we_lo_d;
  logic        we_hi_q, we_hi_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] dati_q, dati_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic [15:0] a_dout_q, a_dout_d;
  logic [15:0] b_dout_q, b_dout_d;
  logic        grant_a, grant_b;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    skip_d   = skip_q;
    sel_b_d  = sel_b_q;
    mask_d   = mask_q;
    ce_d     = ce_q;
    oe_d     = oe_q;
    we_lo_d  = 1'b0;
    we_hi_d  = 1'b0;
    addr_d   = addr_q;
    dati_d   = dati_q;
    a_ack_d  = 1'b0;
    b_ack_d  = 1'b0;
    a_dout_d = a_dout_q;
    b_dout_d = b_dout_q;
    grant_a  = 1'b0;
    grant_b  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // B is forced once A has won B_MAX_SKIP times in a row against it.
        if (bus.b_req && (skip_q == SKIP_MAX)) begin
          grant_b = 1'b1;
        end else if (bus.a_req) begin
          grant_a = 1'b1;
        end else if (bus.b_req) begin
          grant_b = 1'b1;
        end

        if (grant_a) begin
          sel_b_d = 1'b0;
          addr_d  = bus.a_addr;
          dati_d  = bus.a_din;
          mask_d  = {bus.a_we_hi, bus.a_we_lo};
          if (!bus.b_req) begin
            skip_d = 4'd0;
          end else if (skip_q != SKIP_MAX) begin
            skip_d = skip_q + 4'd1;
          end
        end else if (grant_b) begin
          sel_b_d = 1'b1;
          addr_d  = bus.b_addr;
          dati_d  = bus.b_din;
          mask_d  = {bus.b_we_hi, bus.b_we_lo};
          skip_d  = 4'd0;
        end

        if (grant_a || grant_b) begin
          ce_d    = 1'b1;
          oe_d    = (mask_d == 2'b00);
          cnt_d   = CNT_LOAD;
          state_d = ACC;
        end
      end

      ACC: begin
        if (cnt_q == 4'd0) begin
          state_d = GAP;
          ce_d    = 1'b0;
          oe_d    = 1'b0;
          if (sel_b_q) begin
            b_ack_d = 1'b1;
            if (mask_q == 2'b00) b_dout_d = bus.ram0_dato;
          end else begin
            a_ack_d = 1'b1;
            if (mask_q == 2'b00) a_dout_d = bus.ram0_dato;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
          // Strobes are registered one cycle ahead: cnt_q >= 2 means the next
          // cycle is neither the address-setup cycle nor the data-hold cycle.
          we_lo_d = mask_q[0] && (cnt_q >= 4'd2);
          we_hi_d = mask_q[1] && (cnt_q >= 4'd2);
        end
      end

      GAP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      skip_q   <= 4'd0;
      sel_b_q  <= 1'b0;
      mask_q   <= 2'b00;
      ce_q     <= 1'b0;
      oe_q     <= 1'b0;
      we_lo_q  <= 1'b0;
      we_hi_q  <= 1'b0;
      addr_q   <= 23'd0;
      dati_q   <= 16'd0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      a_dout_q <= 16'd0;
      b_dout_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      skip_q   <= skip_d;
      sel_b_q  <= sel_b_d;
      mask_q   <= mask_d;
      ce_q     <= ce_d;
      oe_q     <= oe_d;
      we_lo_q  <= we_lo_d;
      we_hi_q  <= we_hi_d;
      addr_q   <= addr_d;
      dati_q   <= dati_d;
      a_ack_q  <= a_ack_d;
      b_ack_q  <= b_ack_d;
      a_dout_q <= a_dout_d;
      b_dout_q <= b_dout_d;
    end
  end

  assign bus.ram0_ce    = ce_q;
  assign bus.ram0_oe    = oe_q;
  assign bus.ram0_we_lo = we_lo_q;
  assign bus.ram0_we_hi = we_hi_q;
  assign bus.ram0_addr  = addr_q;
  assign bus.ram0_dati  = dati_q;
  assign bus.a_ack      = a_ack_q;
  assign bus.b_ack      = b_ack_q;
  assign bus.a_dout     = a_dout_q;
  assign bus.b_dout     = b_dout_q;

endmodule

// File: tb/tb_psram_arb.sv
// tb/tb_psram_arb.sv - self-checking bench for psram_arb
module tb_psram_arb;
  localparam int ACC_CYC    = 4;
  localparam int B_MAX_SKIP = 2;
  localparam int NV         = 8;
  localparam int N_RAND     = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  psram_arb_if bus ();

  psram_arb #(.ACC_CYC(ACC_CYC), .B_MAX_SKIP(B_MAX_SKIP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // PSRAM model: word array, combinational read while OE, byte writes while CE and WE.
  logic [15:0] mem     [0:1023];
  logic [15:0] ref_mem [0:1023];
  assign bus.ram0_dato = bus.ram0_oe ? mem[bus.ram0_addr[10:1]] : 16'hDEAD;
  always @(posedge clk) begin
    if (bus.ram0_ce && bus.ram0_we_lo) mem[bus.ram0_addr[10:1]][7:0]  <= bus.ram0_dati[7:0];
    if (bus.ram0_ce && bus.ram0_we_hi) mem[bus.ram0_addr[10:1]][15:8] <= bus.ram0_dati[15:8];
  end

  // Access monitor: profile of each CE-high window, plus the order of acks.
  int          mon_pos, mon_ce_cnt, mon_oe_cnt, mon_first_cyc, mon_low_len;
  int          mon_fall_cyc = -1;
  logic [15:0] mon_we_lo_mask, mon_we_hi_mask;
  logic [22:0] mon_addr;
  logic [15:0] mon_dati;
  logic        ce_prev = 1'b0;
  bit          mon_en  = 1'b1;
  int          ack_log[$];
  int          skip_log[$];

  always @(negedge clk) begin
    if (bus.ram0_ce) begin
      if (!ce_prev) begin
        mon_pos        = 0;
        mon_ce_cnt     = 0;
        mon_oe_cnt     = 0;
        mon_we_lo_mask = '0;
        mon_we_hi_mask = '0;
        mon_first_cyc  = cyc;
        mon_addr       = bus.ram0_addr;
        mon_dati       = bus.ram0_dati;
        mon_low_len    = cyc - mon_fall_cyc;
      end
      mon_ce_cnt++;
      if (bus.ram0_oe)    mon_oe_cnt++;
      if (bus.ram0_we_lo) mon_we_lo_mask[mon_pos] = 1'b1;
      if (bus.ram0_we_hi) mon_we_hi_mask[mon_pos] = 1'b1;
      if (mon_pos < 15) mon_pos++;
    end else if (ce_prev) begin
      mon_fall_cyc = cyc;
      if (mon_en) check("ce_len", 32'(mon_ce_cnt), 32'(ACC_CYC));
    end
    ce_prev = bus.ram0_ce;
    if (bus.a_ack) begin ack_log.push_back(0); skip_log.push_back(int'(dut.skip_q)); end
    if (bus.b_ack) begin ack_log.push_back(1); skip_log.push_back(int'(dut.skip_q)); end
  end

  // Requester: raise req at a negedge, wait for ack, drop req on the ack cycle.
  task automatic do_req(input bit port, input logic [22:0] addr, input logic [15:0] din,
                        input logic [1:0] we, output logic [15:0] dout,
                        output int ack_cyc, output int req_cyc);
    if (port == 1'b0) begin
      bus.a_addr = addr; bus.a_din = din; bus.a_we_lo = we[0]; bus.a_we_hi = we[1]; bus.a_req = 1'b1;
    end else begin
      bus.b_addr = addr; bus.b_din = din; bus.b_we_lo = we[0]; bus.b_we_hi = we[1]; bus.b_req = 1'b1;
    end
    req_cyc = cyc;
    ack_cyc = -1;
    dout    = 16'h0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((port == 1'b0) ? bus.a_ack : bus.b_ack) begin
        ack_cyc = cyc;
        dout    = (port == 1'b0) ? bus.a_dout : bus.b_dout;
        break;
      end
    end
    if (port == 1'b0) bus.a_req = 1'b0; else bus.b_req = 1'b0;
    if (ack_cyc < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_timeout: port %0d got no ack within 200 cycles, expected an ack", port);
    end
  endtask

  // Higher-level reference: serialized memory updated in ack order, and a
  // count of A accesses granted while a B request was waiting.
  bit b_pending   = 1'b0;
  int b_raise_cyc = 0;
  int a_while_b   = 0;

  task automatic model_apply(input bit port, input int idx, input logic [15:0] din,
                             input logic [1:0] we, input logic [15:0] dout, input int ack_cyc);
    if (ack_cyc < 0) return;
    if (we == 2'b00) begin
      check(port ? "rand_b_dout" : "rand_a_dout", 32'(dout), 32'(ref_mem[idx]));
    end else begin
      if (we[0]) ref_mem[idx][7:0]  = din[7:0];
      if (we[1]) ref_mem[idx][15:8] = din[15:8];
    end
    if (port == 1'b0) begin
      if (b_pending && (ack_cyc - ACC_CYC > b_raise_cyc)) a_while_b++;
    end else begin
      check("rand_b_wait_excess", (a_while_b <= B_MAX_SKIP) ? 32'd0 : 32'(a_while_b), 32'd0);
      b_pending = 1'b0;
      a_while_b = 0;
    end
  endtask

  typedef struct {
    bit          port;
    logic [22:0] addr;
    logic [15:0] din;
    logic [1:0]  we;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t        vecs [NV];
  logic [15:0] we_mask;
  logic [15:0] dout, dout_a, dout_b;
  int          ack_cyc, req_cyc, ack_a, ack_b, rc_a, rc_b;
  bit          is_rd;
  int          exp_skip [6];
  int          exp_order[6];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 7 + 16'h3000);
    mem[10'h080] = 16'hBEEF;
    mem[10'h181] = 16'h7700;
    bus.a_req = 1'b0; bus.a_addr = '0; bus.a_din = '0; bus.a_we_lo = 1'b0; bus.a_we_hi = 1'b0;
    bus.b_req = 1'b0; bus.b_addr = '0; bus.b_din = '0; bus.b_we_lo = 1'b0; bus.b_we_hi = 1'b0;

    we_mask = '0;
    for (int k = 1; k <= ACC_CYC - 2; k++) we_mask[k] = 1'b1;

    vecs[0] = '{1'b0, 23'h000100, 16'h0000, 2'b00, 16'hBEEF};
    vecs[1] = '{1'b1, 23'h000200, 16'h1234, 2'b11, 16'h0000};
    vecs[2] = '{1'b1, 23'h000200, 16'h0000, 2'b00, 16'h1234};
    vecs[3] = '{1'b0, 23'h000300, 16'h1111, 2'b11, 16'h0000};
    vecs[4] = '{1'b1, 23'h000300, 16'hAB55, 2'b10, 16'h0000};
    vecs[5] = '{1'b0, 23'h000300, 16'h0000, 2'b00, 16'hAB11};
    vecs[6] = '{1'b0, 23'h000302, 16'h00CD, 2'b01, 16'h0000};
    vecs[7] = '{1'b1, 23'h000302, 16'h0000, 2'b00, 16'h77CD};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_strobes", 32'({bus.ram0_ce, bus.ram0_oe, bus.ram0_we_lo, bus.ram0_we_hi}), 32'd0);
    check("rst_addr", 32'(bus.ram0_addr), 32'd0);
    check("rst_dati", 32'(bus.ram0_dati), 32'd0);
    check("rst_acks", 32'({bus.a_ack, bus.b_ack}), 32'd0);
    check("rst_douts", {bus.a_dout, bus.b_dout}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven single accesses
    for (int i = 0; i < NV; i++) begin
      ack_log.delete();
      do_req(vecs[i].port, vecs[i].addr, vecs[i].din, vecs[i].we, dout, ack_cyc, req_cyc);
      @(negedge clk);
      is_rd = (vecs[i].we == 2'b00);
      if (is_rd) check($sformatf("v%0d_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
      check($sformatf("v%0d_grant_delay", i), 32'(mon_first_cyc - req_cyc), 32'd1);
      check($sformatf("v%0d_ack_cycle", i), 32'(ack_cyc - mon_first_cyc + 1), 32'(ACC_CYC + 1));
      check($sformatf("v%0d_oe_cycles", i), 32'(mon_oe_cnt), is_rd ? 32'(ACC_CYC) : 32'd0);
      check($sformatf("v%0d_we_lo_pos", i), 32'(mon_we_lo_mask), vecs[i].we[0] ? 32'(we_mask) : 32'd0);
      check($sformatf("v%0d_we_hi_pos", i), 32'(mon_we_hi_mask), vecs[i].we[1] ? 32'(we_mask) : 32'd0);
      check($sformatf("v%0d_addr", i), 32'(mon_addr), 32'(vecs[i].addr));
      if (!is_rd) check($sformatf("v%0d_dati", i), 32'(mon_dati), 32'(vecs[i].din));
      check($sformatf("v%0d_ack_count", i), 32'(ack_log.size()), 32'd1);
      if (ack_log.size() > 0) check($sformatf("v%0d_ack_port", i), 32'(ack_log[0]), 32'(vecs[i].port));
    end

    // Simultaneous requests with skip=0: A first, B in the next IDLE.
    ack_log.delete();
    fork
      do_req(1'b0, 23'h000100, 16'h0, 2'b00, dout_a, ack_a, rc_a);
      do_req(1'b1, 23'h000200, 16'h0, 2'b00, dout_b, ack_b, rc_b);
    join
    @(negedge clk);
    check("sim_first_ack", ack_log.size() > 0 ? 32'(ack_log[0]) : 32'd9, 32'd0);
    check("sim_ack_spacing", 32'(ack_b - ack_a), 32'(ACC_CYC + 2));
    check("sim_ce_low_between", 32'(mon_low_len), 32'd2);
    check("sim_a_dout", 32'(dout_a), 32'hBEEF);
    check("sim_b_dout", 32'(dout_b), 32'h1234);

    // A hammers while B stays pending: B is forced every B_MAX_SKIP A grants.
    exp_order = '{0, 0, 1, 0, 0, 1};
    exp_skip  = '{1, 2, 0, 1, 2, 0};
    ack_log.delete();
    skip_log.delete();
    fork
      begin
        logic [15:0] d; int ac, rc;
        for (int i = 0; i < 4; i++) do_req(1'b0, 23'h000100, 16'h0, 2'b00, d, ac, rc);
      end
      begin
        logic [15:0] d; int ac, rc;
        for (int i = 0; i < 2; i++) do_req(1'b1, 23'h000200, 16'h0, 2'b00, d, ac, rc);
      end
    join
    @(negedge clk);
    check("starve_ack_count", 32'(ack_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < ack_log.size()) begin
        check($sformatf("starve_order_%0d", i), 32'(ack_log[i]), 32'(exp_order[i]));
        check($sformatf("starve_skip_%0d", i), 32'(skip_log[i]), 32'(exp_skip[i]));
      end
    end

    // Reset in ACC cycle 2 of an A write aborts it asynchronously.
    mon_en = 1'b0;
    ack_log.delete();
    bus.a_addr = 23'h000400; bus.a_din = 16'h5555; bus.a_we_lo = 1'b1; bus.a_we_hi = 1'b1;
    bus.a_req  = 1'b1;
    for (int i = 0; i < 20 && !bus.ram0_ce; i++) @(negedge clk);
    check("abort_ce_seen", 32'(bus.ram0_ce), 32'd1);
    repeat (2) @(negedge clk);
    check("abort_we_before", 32'({bus.ram0_we_lo, bus.ram0_we_hi}), 32'h3);
    #2 rst = 1'b0;
    #1;
    check("abort_ce_async", 32'(bus.ram0_ce), 32'd0);
    check("abort_we_async", 32'({bus.ram0_we_lo, bus.ram0_we_hi}), 32'd0);
    check("abort_a_dout", 32'(bus.a_dout), 32'd0);
    bus.a_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_no_ack", 32'(ack_log.size()), 32'd0);
    check("abort_idle_ce", 32'(bus.ram0_ce), 32'd0);
    mon_en = 1'b1;
    do_req(1'b0, 23'h000100, 16'h0, 2'b00, dout, ack_cyc, req_cyc);
    @(negedge clk);
    check("after_rst_dout", 32'(dout), 32'hBEEF);
    check("after_rst_ack_cycle", 32'(ack_cyc - mon_first_cyc + 1), 32'(ACC_CYC + 1));

    // Randomized traffic on both ports against the reference model.
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
    fork
      begin
        logic [15:0] d, di; int ac, rc, idx; logic [22:0] ad; logic [1:0] w;
        for (int i = 0; i < N_RAND; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          idx = 32'h200 + int'($urandom_range(0, 31));
          ad  = 23'(idx << 1) | 23'($urandom_range(0, 1));
          w   = 2'($urandom_range(0, 3));
          di  = 16'($urandom);
          do_req(1'b0, ad, di, w, d, ac, rc);
          model_apply(1'b0, idx, di, w, d, ac);
        end
      end
      begin
        logic [15:0] d, di; int ac, rc, idx; logic [22:0] ad; logic [1:0] w;
        for (int i = 0; i < N_RAND; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          idx = 32'h200 + int'($urandom_range(0, 31));
          ad  = 23'(idx << 1) | 23'($urandom_range(0, 1));
          w   = 2'($urandom_range(0, 3));
          di  = 16'($urandom);
          b_raise_cyc = cyc;
          b_pending   = 1'b1;
          do_req(1'b1, ad, di, w, d, ac, rc);
          model_apply(1'b1, idx, di, w, d, ac);
        end
      end
    join
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/psram_arb.md
Name: psram_arb

Overview:
- Two-requester arbiter and access sequencer for the cartridge PSRAM bus (ram0_* signals).
- Port A serves the MD CPU-side mapper and has priority. Port B serves MCU/SPI DMA (ROM load, save-state transfer) and has a bounded wait.
- Generates registered CE/OE/WE-byte strobes with a fixed access length, then a mandatory CE-high recovery cycle.
- Sits between the everdrive core logic and the top-level PSRAM pin mapping.

Parameters:
ACC_CYC, 4, clk cycles CE is held low per access; legal range 3..15.
B_MAX_SKIP, 2, consecutive A grants tolerated while B is pending before B is forced; legal range 1..15.

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  asynchronous active-low reset
a_req  in  1  port A request level; addr/din/we held stable until a_ack
a_addr  in  23  port A byte address (bit0 ignored by PSRAM)
a_din  in  16  port A write data
a_we_lo  in  1  port A low-byte write; a_we_lo=a_we_hi=0 means read
a_we_hi  in  1  port A high-byte write
a_dout  out  16  port A read data
a_ack  out  1  port A one-cycle completion pulse
b_req, b_addr, b_din, b_we_lo, b_we_hi, b_dout, b_ack  same as port A, for port B
ram0_dato  in  16  PSRAM read data
ram0_dati  out  16  PSRAM write data
ram0_addr  out  23  PSRAM address
ram0_ce  out  1  chip enable, active-high
ram0_oe  out  1  output enable, active-high
ram0_we_lo  out  1  low-byte write strobe, active-high
ram0_we_hi  out  1  high-byte write strobe, active-high

Behaviour:
- FSM states: IDLE, ACC, GAP. All outputs are registered.
- Reset (asynchronous, rst=0), effective immediately:
  - state=IDLE, all ram0_* = 0, a_ack = b_ack = 0, a_dout = b_dout = 0, skip counter = 0.
  - Reset during ACC aborts the access with no ack; the requesters must reissue.
- IDLE, grant selection:
  - If b_req and skip==B_MAX_SKIP: grant B.
  - Else if a_req: grant A.
  - Else if b_req: grant B.
  - Otherwise stay in IDLE.
- IDLE, on grant:
  - Latch the granted addr/din/we into ram0_addr/ram0_dati and an internal write-mask.
  - Set ram0_ce=1; set ram0_oe=1 if the access is a read.
  - Load cnt=ACC_CYC-1; go to ACC.
- Skip counter:
  - An A grant while b_req=1 increments skip (saturating at B_MAX_SKIP).
  - Any B grant clears skip to 0.
  - An A grant with b_req=0 clears skip to 0.
- ACC:
  - ram0_ce stays 1; ram0_addr and ram0_dati are held.
  - Write: ram0_we_lo/hi follow the mask for access cycles 1..ACC_CYC-2 (0 in cycle 0 for address setup, 0 in the last cycle for data hold).
  - Read: ram0_oe=1 for all ACC_CYC cycles.
  - cnt decrements each cycle. At cnt==0: go to GAP; on a read, register ram0_dato into the granted port's dout.
- GAP, exactly one cycle:
  - ram0_ce = ram0_oe = ram0_we_* = 0.
  - Granted port's ack=1.
  - Next state is IDLE.
- ack and dout:
  - ack is high only in the GAP cycle.
  - dout is valid from the ack cycle and holds until the next completed read on that port; writes do not change dout.
- Requester protocol:
  - The requester drops req on the clock edge where it samples ack=1.
  - A req still high in the following IDLE cycle is a new request.
- Latency and throughput:
  - req high in IDLE → ack high ACC_CYC+1 cycles after the grant edge.
  - Sustained throughput is one access per ACC_CYC+2 cycles.
- Simultaneous a_req/b_req with skip<B_MAX_SKIP: A wins.
- A request arriving during ACC/GAP waits; an access is never preempted.
- Idle outputs: ram0_addr and ram0_dati hold their last values.
- Inputs are assumed synchronous to clk; cross-domain synchronisation is done upstream.

Test Plan:
- Single A read at 0x000100 (model returns 0xBEEF), ACC_CYC=4:
  - ram0_ce high for exactly 4 cycles with oe=1, we=0.
  - a_ack pulses 5 cycles after the grant edge; a_dout=0xBEEF.
- B word write 0x1234 to 0x000200, then B read of the same address:
  - Write: we_lo and we_hi high in access cycles 1..2 only; ram0_dati=0x1234.
  - Read: b_dout=0x1234.
- Byte write (b_we_hi only, din 0xAB55) over a location holding 0x1111:
  - Only ram0_we_hi pulses.
  - Readback = 0xAB11.
- a_req and b_req asserted in the same cycle, skip=0:
  - A granted first; B granted in the next IDLE.
  - Acks are 6 cycles apart; ram0_ce low for at least 1 cycle between the accesses.
- A re-requests continuously with b_req held, B_MAX_SKIP=2:
  - Grant order A, A, B, A, A, B.
  - skip observed as 1, 2, 0.
- rst pulled low in ACC cycle 2 of an A write:
  - ram0_ce and ram0_we_* drop in the same cycle (asynchronous).
  - No a_ack; a_dout=0.
  - After release, FSM in IDLE and a new request is serviced normally.
